// File: rtl/param_pipe_addsub_pkg.sv
// Shared opcode encodings and the signed-overflow helper for the pipelined add/sub.
package param_pipe_addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Overflow when both addend signs agree and the result sign disagrees with them.
  function automatic logic signed_ovf(input logic a_msb, input logic b_eff_msb, input logic sum_msb);
    return (a_msb == b_eff_msb) && (sum_msb != a_msb);
  endfunction

endpackage

// File: rtl/param_pipe_addsub_segment.sv
// Combinational SEG_W-bit adder slice; one instance per pipeline stage.
module addsub_segment #(
  parameter int SEG_W = 4
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             cin,
  output logic [SEG_W-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, cin};

endmodule

// File: rtl/param_pipe_addsub.sv
// Add/subtract with the carry chain cut into STAGES registered slices, a valid pipe,
// signed-overflow flag and optional unsigned saturation.
module param_pipe_addsub
  import param_pipe_addsub_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int STAGES   = 2,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SEG = (STAGES > 0) ? WIDTH / STAGES : WIDTH;

  logic [WIDTH-1:0] raw_sum;
  logic             op_out;

  generate
    if (WIDTH < 2) begin : g_bad_width
      $error("param_pipe_addsub: WIDTH must be at least 2");
    end
    if (STAGES < 0 || (STAGES > 0 && (WIDTH % ((STAGES > 0) ? STAGES : 1)) != 0)) begin : g_bad_stages
      $error("param_pipe_addsub: WIDTH must be a multiple of STAGES");
    end

    if (STAGES == 0) begin : g_comb
      logic [WIDTH-1:0] b_eff;
      logic             c_eff;

      assign b_eff = (op == OP_SUB) ? ~b : b;
      assign c_eff = (op == OP_SUB) ? ~cin : cin;

      addsub_segment #(.SEG_W(WIDTH)) u_seg (
        .a   (a),
        .b   (b_eff),
        .cin (c_eff),
        .sum (raw_sum),
        .cout(cout)
      );

      assign ovf       = signed_ovf(a[WIDTH-1], b_eff[WIDTH-1], raw_sum[WIDTH-1]);
      assign out_valid = in_valid;
      assign op_out    = op;
    end else begin : g_pipe
      for (genvar gi = 0; gi < STAGES; gi++) begin : g_stg
        // Operand bits still to be added: slice gi and everything above it.
        localparam int HI_W = WIDTH - gi * SEG;

        logic [HI_W-1:0]          a_cur, b_cur;
        logic                     op_cur, c_cur, v_cur;
        logic [SEG-1:0]           b_eff, seg_sum;
        logic                     seg_cout;
        logic [(gi+1)*SEG-1:0]    low_next, low_reg;
        logic                     valid_reg, carry_reg, op_reg;

        if (gi == 0) begin : g_first
          assign a_cur    = a;
          assign b_cur    = b;
          assign op_cur   = op;
          assign c_cur    = (op == OP_SUB) ? ~cin : cin;
          assign v_cur    = in_valid;
          assign low_next = seg_sum;
        end else begin : g_next
          assign a_cur    = g_stg[gi-1].g_fwd.a_fwd_reg;
          assign b_cur    = g_stg[gi-1].g_fwd.b_fwd_reg;
          assign op_cur   = g_stg[gi-1].op_reg;
          assign c_cur    = g_stg[gi-1].carry_reg;
          assign v_cur    = g_stg[gi-1].valid_reg;
          assign low_next = {seg_sum, g_stg[gi-1].low_reg};
        end

        assign b_eff = (op_cur == OP_SUB) ? ~b_cur[SEG-1:0] : b_cur[SEG-1:0];

        addsub_segment #(.SEG_W(SEG)) u_seg (
          .a   (a_cur[SEG-1:0]),
          .b   (b_eff),
          .cin (c_cur),
          .sum (seg_sum),
          .cout(seg_cout)
        );

        // Lower result slices ride along in low_reg, which doubles as the output deskew.
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            valid_reg <= 1'b0;
            carry_reg <= 1'b0;
            op_reg    <= 1'b0;
            low_reg   <= '0;
          end else begin
            valid_reg <= v_cur;
            if (v_cur) begin
              carry_reg <= seg_cout;
              op_reg    <= op_cur;
              low_reg   <= low_next;
            end
          end
        end

        if (gi < STAGES - 1) begin : g_fwd
          logic [HI_W-SEG-1:0] a_fwd_reg, b_fwd_reg;

          always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
              a_fwd_reg <= '0;
              b_fwd_reg <= '0;
            end else if (v_cur) begin
              a_fwd_reg <= a_cur[HI_W-1:SEG];
              b_fwd_reg <= b_cur[HI_W-1:SEG];
            end
          end
        end else begin : g_last
          logic ovf_reg;

          always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
              ovf_reg <= 1'b0;
            end else if (v_cur) begin
              ovf_reg <= signed_ovf(a_cur[SEG-1], b_eff[SEG-1], seg_sum[SEG-1]);
            end
          end
        end
      end

      assign out_valid = g_stg[STAGES-1].valid_reg;
      assign raw_sum   = g_stg[STAGES-1].low_reg;
      assign cout      = g_stg[STAGES-1].carry_reg;
      assign ovf       = g_stg[STAGES-1].g_last.ovf_reg;
      assign op_out    = g_stg[STAGES-1].op_reg;
    end
  endgenerate

  // Saturation is applied after the last register so cout/ovf keep their raw meaning.
  always_comb begin
    sum = raw_sum;
    if (SATURATE != 0) begin
      if (op_out == OP_ADD && cout) begin
        sum = '1;
      end else if (op_out == OP_SUB && !cout) begin
        sum = '0;
      end
    end
  end

endmodule

// File: tb/tb_param_pipe_addsub.sv
// Directed and scoreboard checks of three configurations: 8b/2-stage wrap,
// 8b/4-stage saturating and 4b combinational.
module tb_param_pipe_addsub;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       v0, op0, cin0, ov0, c0, f0;
  logic [7:0] a0, b0, s0;
  logic       v1, op1, cin1, ov1, c1, f1;
  logic [7:0] a1, b1, s1;
  logic       v2, op2, cin2, ov2, c2, f2;
  logic [3:0] a2, b2, s2;

  int checks = 0;
  int errors = 0;

  logic [7:0] ra [0:23];
  logic [7:0] rb [0:23];
  logic       rop [0:23];
  logic       rcin [0:23];
  logic       rv [0:23];
  logic [9:0] exp0, exp1;

  always #5 clk = ~clk;

  param_pipe_addsub #(.WIDTH(8), .STAGES(2), .SATURATE(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(v0), .op(op0), .a(a0), .b(b0), .cin(cin0),
    .out_valid(ov0), .sum(s0), .cout(c0), .ovf(f0)
  );

  param_pipe_addsub #(.WIDTH(8), .STAGES(4), .SATURATE(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(v1), .op(op1), .a(a1), .b(b1), .cin(cin1),
    .out_valid(ov1), .sum(s1), .cout(c1), .ovf(f1)
  );

  param_pipe_addsub #(.WIDTH(4), .STAGES(0), .SATURATE(0)) u2 (
    .clk(clk), .rst(rst), .in_valid(v2), .op(op2), .a(a2), .b(b2), .cin(cin2),
    .out_valid(ov2), .sum(s2), .cout(c2), .ovf(f2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  // Reference: {ovf, cout, sum} computed with integer arithmetic and a signed range test.
  function automatic logic [9:0] model(input int w, input bit sat, input logic op,
                                       input logic [7:0] a, input logic [7:0] b, input logic cin);
    int av, bv, mask, half, full, sa, sb, s;
    logic co, ov;
    logic [7:0] r;
    mask = (1 << w) - 1;
    half = 1 << (w - 1);
    av   = int'(a) & mask;
    bv   = int'(b) & mask;
    if (!op) full = av + bv + int'(cin);
    else     full = av - bv - int'(cin) + (1 << w);
    co = ((full >> w) & 1) != 0;
    r  = 8'(full & mask);
    sa = (av >= half) ? av - (1 << w) : av;
    sb = op ? ((~bv) & mask) : bv;
    if (sb >= half) sb = sb - (1 << w);
    s  = sa + sb + (op ? int'(!cin) : int'(cin));
    ov = (s >= half) || (s < -half);
    if (sat && !op && co) r = 8'(mask);
    if (sat && op && !co) r = 8'h00;
    return {ov, co, r};
  endfunction

  initial begin
    v0 = 0; op0 = 0; cin0 = 0; a0 = 0; b0 = 0;
    v1 = 0; op1 = 0; cin1 = 0; a1 = 0; b1 = 0;
    v2 = 0; op2 = 0; cin2 = 0; a2 = 0; b2 = 0;

    // Reset state
    tick(); tick();
    chk("rst_u0_valid", ov0, 0); chk("rst_u0_sum", s0, 0);
    chk("rst_u0_cout", c0, 0);   chk("rst_u0_ovf", f0, 0);
    chk("rst_u1_valid", ov1, 0); chk("rst_u1_sum", s1, 0);
    rst = 1;
    tick();

    // 0x7F + 0x01: signed overflow, two-cycle latency
    v0 = 1; op0 = 0; a0 = 8'h7F; b0 = 8'h01; cin0 = 0;
    tick();
    chk("t1_early_valid", ov0, 0);
    v0 = 0;
    tick();
    chk("t1_valid", ov0, 1); chk("t1_sum", s0, 8'h80);
    chk("t1_cout", c0, 0);   chk("t1_ovf", f0, 1);

    // Back-to-back subtracts with borrow-in
    v0 = 1; op0 = 1; a0 = 8'h05; b0 = 8'h07; cin0 = 1;
    tick();
    chk("t2_bubble_valid", ov0, 0);
    a0 = 8'h80; b0 = 8'h01; cin0 = 0;
    tick();
    chk("t2a_valid", ov0, 1); chk("t2a_sum", s0, 8'hFD);
    chk("t2a_cout", c0, 0);   chk("t2a_ovf", f0, 0);
    v0 = 0;
    tick();
    chk("t2b_valid", ov0, 1); chk("t2b_sum", s0, 8'h7F);
    chk("t2b_cout", c0, 1);   chk("t2b_ovf", f0, 1);
    tick();
    chk("t2_hold_valid", ov0, 0); chk("t2_hold_sum", s0, 8'h7F);
    chk("t2_hold_cout", c0, 1);   chk("t2_hold_ovf", f0, 1);

    // Saturating, four stages
    v1 = 1; op1 = 0; a1 = 8'hF0; b1 = 8'h20; cin1 = 0;
    tick();
    op1 = 1; a1 = 8'h10; b1 = 8'h20;
    tick();
    v1 = 0;
    tick();
    chk("t3_early_valid", ov1, 0);
    tick();
    chk("t3a_valid", ov1, 1); chk("t3a_sum", s1, 8'hFF);
    chk("t3a_cout", c1, 1);   chk("t3a_ovf", f1, 0);
    tick();
    chk("t3b_valid", ov1, 1); chk("t3b_sum", s1, 8'h00);
    chk("t3b_cout", c1, 0);   chk("t3b_ovf", f1, 0);
    tick();
    chk("t3_hold_valid", ov1, 0); chk("t3_hold_sum", s1, 8'h00);

    // Combinational configuration
    v2 = 1; op2 = 0; a2 = 4'hF; b2 = 4'h1; cin2 = 1;
    #1;
    chk("t4a_valid", ov2, 1); chk("t4a_sum", s2, 4'h1);
    chk("t4a_cout", c2, 1);   chk("t4a_ovf", f2, 0);
    op2 = 1; a2 = 4'h3; b2 = 4'h5; cin2 = 1;
    #1;
    chk("t4b_sum", s2, 4'hD); chk("t4b_cout", c2, 0); chk("t4b_ovf", f2, 0);
    op2 = 0; a2 = 4'h7; b2 = 4'h1; cin2 = 0;
    #1;
    chk("t4c_sum", s2, 4'h8); chk("t4c_cout", c2, 0); chk("t4c_ovf", f2, 1);
    v2 = 0;
    #1;
    chk("t4d_valid", ov2, 0);

    // Random stream with a 1,1,0 valid pattern on both pipelined instances
    for (int c = 0; c < 24; c++) begin
      ra[c]   = 8'($urandom_range(0, 255));
      rb[c]   = 8'($urandom_range(0, 255));
      rop[c]  = 1'($urandom_range(0, 1));
      rcin[c] = 1'($urandom_range(0, 1));
      rv[c]   = (c < 20) && ((c % 3) != 2);
    end
    exp0 = {1'b1, 1'b1, 8'h7F};
    exp1 = {1'b0, 1'b0, 8'h00};
    for (int c = 0; c < 24; c++) begin
      v0 = rv[c]; op0 = rop[c]; a0 = ra[c]; b0 = rb[c]; cin0 = rcin[c];
      v1 = rv[c]; op1 = rop[c]; a1 = ra[c]; b1 = rb[c]; cin1 = rcin[c];
      tick();
      if (c >= 1) begin
        if (rv[c-1]) exp0 = model(8, 1'b0, rop[c-1], ra[c-1], rb[c-1], rcin[c-1]);
        chk($sformatf("s0_valid[%0d]", c-1), ov0, rv[c-1]);
        chk($sformatf("s0_sum[%0d]", c-1), s0, exp0[7:0]);
        chk($sformatf("s0_cout[%0d]", c-1), c0, exp0[8]);
        chk($sformatf("s0_ovf[%0d]", c-1), f0, exp0[9]);
      end
      if (c >= 3) begin
        if (rv[c-3]) exp1 = model(8, 1'b1, rop[c-3], ra[c-3], rb[c-3], rcin[c-3]);
        chk($sformatf("s1_valid[%0d]", c-3), ov1, rv[c-3]);
        chk($sformatf("s1_sum[%0d]", c-3), s1, exp1[7:0]);
        chk($sformatf("s1_cout[%0d]", c-3), c1, exp1[8]);
        chk($sformatf("s1_ovf[%0d]", c-3), f1, exp1[9]);
      end
    end

    // Asynchronous reset with operations in flight
    v0 = 1; op0 = 0; a0 = 8'h11; b0 = 8'h22; cin0 = 0;
    v1 = 1; op1 = 0; a1 = 8'h01; b1 = 8'h02; cin1 = 0;
    tick();
    v0 = 0;
    a1 = 8'h03; b1 = 8'h04;
    tick();
    v1 = 0;
    chk("t6_pre_valid", ov0, 1); chk("t6_pre_sum", s0, 8'h33);
    #2 rst = 0;
    #1;
    chk("t6_u0_valid", ov0, 0); chk("t6_u0_sum", s0, 0);
    chk("t6_u0_cout", c0, 0);   chk("t6_u0_ovf", f0, 0);
    chk("t6_u1_valid", ov1, 0); chk("t6_u1_sum", s1, 0);
    chk("t6_u1_cout", c1, 0);   chk("t6_u1_ovf", f1, 0);
    tick();
    rst = 1;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk($sformatf("t6_post_u1_valid[%0d]", c), ov1, 0);
      chk($sformatf("t6_post_u1_sum[%0d]", c), s1, 0);
      chk($sformatf("t6_post_u0_valid[%0d]", c), ov0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
